// File: rtl/wave_phase_ctrl.sv
// Phase generator for the quarter-wave sine DAC stage: sample-rate prescaler plus
// fractional phase accumulator, with reconfiguration deferred to a phase wrap.
module wave_phase_ctrl #(
  parameter int unsigned ACC_BITS = 24,
  parameter int unsigned INDEX_BITS = 9,
  parameter int unsigned DIV_BITS = 16,
  parameter logic [ACC_BITS-1:0] DEFAULT_STEP = 24'h008000,
  parameter logic [DIV_BITS-1:0] DEFAULT_DIV = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ACC_BITS-1:0]   cfg_step,
  input  logic [DIV_BITS-1:0]   cfg_div,
  output logic [INDEX_BITS-1:0] sample_index,
  output logic                  sample_tick,
  output logic                  cycle_wrap
);

  typedef enum logic {CFG_OPEN, CFG_HELD} cfg_state_t;

  cfg_state_t            state_q, state_d;
  logic [ACC_BITS-1:0]   acc_q, acc_d;
  logic [DIV_BITS-1:0]   prescaler_q, prescaler_d;
  logic [ACC_BITS-1:0]   step_active_q, step_active_d;
  logic [DIV_BITS-1:0]   div_active_q, div_active_d;
  logic [ACC_BITS-1:0]   step_pend_q, step_pend_d;
  logic [DIV_BITS-1:0]   div_pend_q, div_pend_d;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;
  logic                  tick;
  logic [ACC_BITS:0]     sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CFG_OPEN;
      acc_q         <= '0;
      prescaler_q   <= '0;
      step_active_q <= DEFAULT_STEP;
      div_active_q  <= DEFAULT_DIV;
      step_pend_q   <= '0;
      div_pend_q    <= '0;
      tick_q        <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      prescaler_q   <= prescaler_d;
      step_active_q <= step_active_d;
      div_active_q  <= div_active_d;
      step_pend_q   <= step_pend_d;
      div_pend_q    <= div_pend_d;
      tick_q        <= tick_d;
      wrap_q        <= wrap_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    prescaler_d   = prescaler_q;
    step_active_d = step_active_q;
    div_active_d  = div_active_q;
    step_pend_d   = step_pend_q;
    div_pend_d    = div_pend_q;
    tick_d        = 1'b0;
    wrap_d        = 1'b0;

    tick = enable && (prescaler_q == div_active_q);
    sum  = {1'b0, acc_q} + {1'b0, step_active_q};

    if (enable) begin
      prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    end
    if (tick) begin
      acc_d  = sum[ACC_BITS-1:0];
      tick_d = 1'b1;
      wrap_d = sum[ACC_BITS];
    end

    // The carrying add above still uses the old step; the new settings take
    // over from the following tick period, restarted from a zero prescaler.
    case (state_q)
      CFG_OPEN: begin
        if (cfg_valid) begin
          step_pend_d = cfg_step;
          div_pend_d  = cfg_div;
          state_d     = CFG_HELD;
        end
      end
      CFG_HELD: begin
        if (!enable || (tick && sum[ACC_BITS])) begin
          step_active_d = step_pend_q;
          div_active_d  = div_pend_q;
          prescaler_d   = '0;
          state_d       = CFG_OPEN;
        end
      end
      default: state_d = CFG_OPEN;
    endcase
  end

  assign cfg_ready    = (state_q == CFG_OPEN);
  assign sample_index = acc_q[ACC_BITS-1 -: INDEX_BITS];
  assign sample_tick  = tick_q;
  assign cycle_wrap   = wrap_q;

endmodule

// File: tb/tb_wave_phase_ctrl.sv
// Scoreboard bench for wave_phase_ctrl: a behavioural phase model queues the
// expected outputs per cycle, a monitor on the falling edge pops and compares.
module tb_wave_phase_ctrl;

  localparam longint ACC_MOD = 64'd1 << 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_step;
  logic [15:0] cfg_div;
  logic [8:0]  sample_index;
  logic        sample_tick;
  logic        cycle_wrap;

  always #5 clk = ~clk;

  wave_phase_ctrl #(
    .ACC_BITS(24),
    .INDEX_BITS(9),
    .DIV_BITS(16),
    .DEFAULT_STEP(24'h008000),
    .DEFAULT_DIV(16'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_step(cfg_step),
    .cfg_div(cfg_div),
    .sample_index(sample_index),
    .sample_tick(sample_tick),
    .cycle_wrap(cycle_wrap)
  );

  typedef struct packed {
    logic [8:0] idx;
    logic       tick;
    logic       wrap;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Behavioural model: phase as an integer modulo 2^24, tick countdown as a counter.
  longint m_acc, m_step, p_step;
  int     m_pres, m_div, p_div;
  bit     m_pend, m_tick, m_wrap;

  task automatic model_reset();
    m_acc = 0; m_pres = 0; m_step = 64'h8000; m_div = 0;
    m_pend = 0; m_tick = 0; m_wrap = 0; p_step = 0; p_div = 0;
  endtask

  task automatic model_edge();
    bit     accept, tick_now;
    longint sum;
    if (rst) begin
      model_reset();
      return;
    end
    accept   = cfg_valid && !m_pend;
    tick_now = enable && (m_pres == m_div);
    m_tick   = tick_now;
    m_wrap   = 0;
    if (enable) m_pres = tick_now ? 0 : m_pres + 1;
    if (tick_now) begin
      sum    = m_acc + m_step;
      m_wrap = (sum >= ACC_MOD);
      m_acc  = sum % ACC_MOD;
    end
    if (m_pend && (!enable || m_wrap)) begin
      m_step = p_step;
      m_div  = p_div;
      m_pres = 0;
      m_pend = 0;
    end
    if (accept) begin
      p_step = longint'(cfg_step);
      p_div  = int'(cfg_div);
      m_pend = 1;
    end
  endtask

  function automatic int model_index();
    return int'(m_acc / 64'h8000);
  endfunction

  task automatic cyc(input bit r, input bit en, input bit v,
                     input logic [23:0] st, input logic [15:0] dv);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst = r; enable = en; cfg_valid = v; cfg_step = st; cfg_div = dv;
    if (r) model_reset();
    e.idx   = 9'(model_index());
    e.tick  = m_tick;
    e.wrap  = m_wrap;
    e.ready = !m_pend;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({sample_index, sample_tick, cycle_wrap, cfg_ready} === e)
        passed++;
      else
        $display("FAIL outputs t=%0t actual idx=%0d tick=%b wrap=%b ready=%b required idx=%0d tick=%b wrap=%b ready=%b",
                 $time, sample_index, sample_tick, cycle_wrap, cfg_ready,
                 e.idx, e.tick, e.wrap, e.ready);
    end
  end

  initial begin
    logic [23:0] st;
    logic [15:0] dv;
    int          guard;

    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_step = '0; cfg_div = '0;
    model_reset();

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 24'h0, 16'h0);

    // Defaults: one index per cycle, wrap after 512 ticks.
    for (int i = 0; i < 520; i++) cyc(0, 1, 0, 24'h0, 16'h0);

    // Divider of 3 via the idle path, then run.
    cyc(0, 0, 1, 24'h008000, 16'd3);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 24'h0, 16'h0);
    for (int i = 0; i < 400; i++) cyc(0, 1, 0, 24'h0, 16'h0);

    // Double step, div 0, offered mid-cycle: applies only at the wrap.
    cyc(0, 1, 1, 24'h010000, 16'd0);
    for (int i = 0; i < 2100; i++) cyc(0, 1, 0, 24'h0, 16'h0);

    // cfg_valid held high continuously with fast-wrapping steps.
    for (int i = 0; i < 300; i++) begin
      st = 24'($urandom_range(24'h100000, 24'hFFFFFF));
      dv = 16'($urandom_range(0, 2));
      cyc(0, 1, 1, st, dv);
    end

    // Pause mid-count with div 3.
    cyc(0, 0, 1, 24'h008000, 16'd3);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 24'h0, 16'h0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 24'h0, 16'h0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 24'h0, 16'h0);

    // Reset with a config pending at index 300.
    cyc(0, 0, 1, 24'h008000, 16'd0);
    guard = 0;
    while (model_index() != 300 && guard < 600) begin
      cyc(0, 1, 0, 24'h0, 16'h0);
      guard++;
    end
    checks++;
    if (guard < 600) passed++;
    else $display("FAIL reach_index300 actual=%0d required=300", model_index());
    cyc(0, 1, 1, 24'h040000, 16'd7);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 24'h0, 16'h0);
    for (int i = 0; i < 2; i++) cyc(1, 1, 0, 24'h0, 16'h0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 24'h0, 16'h0);

    // Random mix of configs, pauses and resets.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom % 4)
        0: st = 24'h0;
        1: st = 24'($urandom);
        2: st = 24'($urandom_range(1, 40)) << 15;
        default: st = 24'($urandom_range(24'hC00000, 24'hFFFFFF));
      endcase
      dv = 16'($urandom_range(0, 4));
      cyc(($urandom % 500) == 0, ($urandom % 10) != 0, ($urandom % 4) == 0, st, dv);
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/wave_phase_ctrl.md
# wave_phase_ctrl

Programmable phase generator that sits directly upstream of the quarter-wave sine DAC stage. It replaces that stage's free-running 0..511 sample counter with a sample-rate prescaler and a fractional phase accumulator. The accumulator's top 9 bits form the sample index. Output frequency and sample rate are reprogrammed through a valid/ready handshake. New settings take effect only at a phase wrap, so the waveform never glitches mid-cycle.

## Interface
- ACC_BITS, 24, phase accumulator width; top INDEX_BITS bits are the sample index.
- INDEX_BITS, 9, sample index width (512 samples per cycle).
- DIV_BITS, 16, prescaler width.
- DEFAULT_STEP, 24'h008000, reset phase step (one index per tick).
- DEFAULT_DIV, 0, reset prescaler terminal count (one tick per clk).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run when high; when low, prescaler and accumulator hold.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  block can accept a config.
- cfg_step  in  ACC_BITS  new phase step.
- cfg_div  in  DIV_BITS  new prescaler terminal count.
- sample_index  out  INDEX_BITS  acc[ACC_BITS-1 -: INDEX_BITS]; feeds the DAC stage's index.
- sample_tick  out  1  one-cycle pulse; sample_index changed on this cycle.
- cycle_wrap  out  1  one-cycle pulse, coincident with sample_tick, when the accumulator carried out.

## Operation
- Reset values:
  - acc = 0, prescaler = 0.
  - step_active = DEFAULT_STEP, div_active = DEFAULT_DIV.
  - pending flag = 0, cfg_ready = 1.
  - sample_tick = 0, cycle_wrap = 0, sample_index = 0.
- Prescaler:
  - If enable is high and prescaler != div_active: prescaler increments.
  - If enable is high and prescaler == div_active, this is a tick edge: prescaler goes to 0.
  - Tick period is div_active+1 clk cycles. div_active = 0 gives a tick every cycle.
- Tick edge behaviour:
  - acc <= acc + step_active, mod 2^ACC_BITS.
  - sample_tick <= 1.
  - cycle_wrap <= carry out of that add.
  - On non-tick edges, sample_tick and cycle_wrap are 0.
- enable low: prescaler, acc and outputs hold; no ticks are produced. When enable returns high, the count resumes from the held prescaler value.
- Config handshake:
  - Transfer occurs on an edge with cfg_valid && cfg_ready.
  - cfg_step and cfg_div are captured into pending registers; the pending flag is set and cfg_ready goes to 0.
  - cfg_ready is a registered output and stays low while the pending flag is set.
- Pending apply:
  - Carry case: on a tick edge whose add carries out, the add uses the old step_active. On that same edge, step_active and div_active load from pending, and the prescaler resets to 0.
  - Idle case: if enable is low with the pending flag set, pending is applied on the next edge and the prescaler resets to 0. acc is not modified.
  - Either way the pending flag clears, and cfg_ready = 1 from the following cycle.
- Step of 0 freezes the index and never carries, so a pending config applies only via the idle (enable low) path.
- Any step value is legal. A step of 2^(ACC_BITS-INDEX_BITS) × k advances the index by k per tick, modulo 2^INDEX_BITS.
- rst asserted mid-operation returns every register to its reset value immediately and discards any pending config. No tick is produced during reset.

## Timing
- sample_index is driven combinationally from the registered acc. It shows the new value in the same cycle that sample_tick is high, and is stable for the whole tick period.
- Latency from a tick edge to the outputs is 0 cycles, because the outputs are registered at that edge.
- Config latency (accept to active) depends on the apply path:
  - Carry path: until the next carry edge.
  - Idle path: 1 edge after accept, if enable is low.
- cfg_ready returns high 1 cycle after apply.
- The earliest back-to-back config accept is 2 edges after the previous accept.
- Simultaneous events:
  - cfg_valid is ignored while cfg_ready is low.
  - A carry in the same cycle as an accept cannot apply that config, because pending is registered at the edge.

## Test plan
- Reset, then enable = 1 with defaults -> index 0,1,2,… changing every cycle with sample_tick high each cycle. Index 511→0 sets cycle_wrap = 1 once per 512 ticks.
- Accept cfg_div = 3 while enable = 0 -> applied on the next edge. Re-enable -> sample_tick every 4th cycle and index +1 per tick.
- With the index at 100, accept cfg_step = 24'h010000 -> stepping stays +1 until the wrap to 0 with cycle_wrap. After the wrap, the index goes 2,4,6…; cfg_ready is low from accept until the cycle after the wrap.
- Hold cfg_valid high continuously -> exactly one transfer per apply. No new config is taken while cfg_ready = 0.
- Toggle enable low for 5 cycles mid-count with div = 3 -> the prescaler holds and the next tick lands at (remaining count) cycles after re-enable.
- Assert rst with a config pending at index 300 -> index returns to 0, cfg_ready = 1, and defaults are restored with the pending config discarded.
